// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds default widths, the hard-wired zero register index and a helper.
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam int WB_NUM_REQ = 3;

    // Writes to this index are architecturally dropped.
    localparam int REG_ZERO = 0;

    // Width of a requester index for an n-way arbiter.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
// Ports: req (request vector), ptr (scan start), grant (one-hot), idx (encoded winner).
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          grant,
    output logic [idx_w(N)-1:0]   idx
);

    localparam int PW = idx_w(N);

    logic [PW:0]   pos;
    logic [PW-1:0] cand;
    logic          found;

    // Scan N slots from ptr; pos wraps back below N with one subtraction
    // because ptr itself is always < N.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            cand = pos[PW-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources.
// Ports: clk/rst/flush; req_valid/req_ready/req_addr/req_data per source;
//        wr_en/wr_addr/wr_data/wr_src to the register file;
//        q_addr_a/b -> q_pend_a/b report writes still in flight.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int DATA_W  = WB_DATA_W,
    parameter int ADDR_W  = WB_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic [2:0]                  wr_src,
    input  logic [ADDR_W-1:0]           q_addr_a,
    input  logic [ADDR_W-1:0]           q_addr_b,
    output logic                        q_pend_a,
    output logic                        q_pend_b
);

    localparam int PW = idx_w(NUM_REQ);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [NUM_REQ-1:0] buf_v;
    logic [ADDR_W-1:0]  buf_addr [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      next_ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;

    logic [ADDR_W-1:0]  in_addr [NUM_REQ];
    logic [DATA_W-1:0]  in_data [NUM_REQ];
    logic [NUM_REQ-1:0] take;

    // Flush masks the arbiter so nothing reaches the write stage.
    assign arb_req   = flush ? '0 : buf_v;
    assign grant_any = |grant;
    assign req_ready = {NUM_REQ{!flush}} & (~buf_v | grant);

    assign next_ptr = (grant_idx == PW'(NUM_REQ - 1)) ?
                      '0 : grant_idx + PW'(1);

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Unpack the flat request buses; zero-index writes complete the
    // handshake but never occupy a buffer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
            in_data[i] = req_data[i*DATA_W +: DATA_W];
            take[i]    = req_valid[i] && req_ready[i] &&
                         (in_addr[i] != ZERO_IDX);
        end
    end

    // Buffer occupancy. A granted entry reloads on the same edge if a
    // new write is taken; otherwise it empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_v <= '0;
        end else if (flush) begin
            buf_v <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (take[i]) begin
                    buf_v[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: it is qualified by buf_v.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take[i]) begin
                buf_addr[i] <= in_addr[i];
                buf_data[i] <= in_data[i];
            end
        end
    end

    // Registered write stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
            rr_ptr  <= '0;
        end else if (grant_any) begin
            wr_en   <= 1'b1;
            wr_addr <= buf_addr[grant_idx];
            wr_data <= buf_data[grant_idx];
            wr_src  <= 3'(grant_idx);
            rr_ptr  <= next_ptr;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Hazard query over buffered entries plus the beat on wr_*.
    always_comb begin
        q_pend_a = wr_en && (wr_addr == q_addr_a);
        q_pend_b = wr_en && (wr_addr == q_addr_b);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (buf_v[i] && (buf_addr[i] == q_addr_a)) begin
                q_pend_a = 1'b1;
            end
            if (buf_v[i] && (buf_addr[i] == q_addr_b)) begin
                q_pend_b = 1'b1;
            end
        end
        if (q_addr_a == ZERO_IDX) begin
            q_pend_a = 1'b0;
        end
        if (q_addr_b == ZERO_IDX) begin
            q_pend_b = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [2:0]        wr_src;
    logic [AW-1:0]     q_addr_a;
    logic [AW-1:0]     q_addr_b;
    logic              q_pend_a;
    logic              q_pend_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state for the random test.
    logic          mv [N];
    logic [AW-1:0] ma [N];
    logic [DW-1:0] md [N];
    int            mptr;
    logic          exp_wen;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    int            exp_wsrc;

    regfile_wb_arbiter #(
        .NUM_REQ(N),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_src   (wr_src),
        .q_addr_a (q_addr_a),
        .q_addr_b (q_addr_b),
        .q_pend_a (q_pend_a),
        .q_pend_b (q_pend_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        q_addr_a  = '0;
        q_addr_b  = '0;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic model_pend(input logic [AW-1:0] q);
        logic p;
        p = exp_wen && (exp_waddr == q);
        for (int i = 0; i < N; i++) begin
            if (mv[i] && ma[i] == q) p = 1'b1;
        end
        return (q != 0) && p;
    endfunction

    task automatic test_reset();
        logic [AW-1:0] qs [4];
        qs[0] = 5'd0; qs[1] = 5'd5; qs[2] = 5'd31; qs[3] = 5'd7;
        idle_inputs();
        rst = 1'b1;
        #3;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_en_in_rst: got %b exp 0", wr_en);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready: got %b exp 111", req_ready);
        end
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_en: got %b exp 0", wr_en);
        end
        for (int k = 0; k < 4; k++) begin
            q_addr_a = qs[k];
            q_addr_b = qs[3-k];
            #1;
            n_checks++;
            if (q_pend_a !== 1'b0 || q_pend_b !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pend q=%0d: got %b%b exp 00",
                         qs[k], q_pend_a, q_pend_b);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 3'b010;
        set_src(1, 5'd5, 32'hDEADBEEF);
        q_addr_a = 5'd5;
        #1;
        n_checks++;
        if (req_ready[1] !== 1'b1 || q_pend_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pre: got rdy=%b pend=%b exp 1 0",
                     req_ready[1], q_pend_a);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || q_pend_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_buffered: got wr_en=%b pend=%b exp 0 1",
                     wr_en, q_pend_a);
        end
        tick();
        n_checks++;
        if ({wr_en, wr_addr, wr_data, wr_src} !==
            {1'b1, 5'd5, 32'hDEADBEEF, 3'd1}) begin
            n_fail++;
            $display("FAIL single_write: got en=%b a=%0d d=%h s=%0d exp 1 5 deadbeef 1",
                     wr_en, wr_addr, wr_data, wr_src);
        end
        n_checks++;
        if (q_pend_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pend_wr: got %b exp 1", q_pend_a);
        end
        tick();
        n_checks++;
        if (wr_en !== 1'b0 || q_pend_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got wr_en=%b pend=%b exp 0 0",
                     wr_en, q_pend_a);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 3'b111;
        set_src(0, 5'd1, 32'hA0A0_0000);
        set_src(1, 5'd2, 32'hA1A1_1111);
        set_src(2, 5'd3, 32'hA2A2_2222);
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (wr_en !== 1'b1 || wr_src !== 3'(c % 3) ||
                wr_addr !== 5'(c % 3 + 1)) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got en=%b src=%0d a=%0d exp 1 %0d %0d",
                         c, wr_en, wr_src, wr_addr, c % 3, c % 3 + 1);
            end
        end
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_zero_addr();
        do_reset();
        req_valid = 3'b001;
        set_src(0, 5'd0, 32'h0000_1234);
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b exp 1", req_ready[0]);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (req_ready !== 3'b111 || q_pend_a !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_unbuffered: got rdy=%b pend=%b exp 111 0",
                     req_ready, q_pend_a);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (wr_en !== 1'b0 || q_pend_a !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_no_write%0d: got en=%b pend=%b exp 0 0",
                         c, wr_en, q_pend_a);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 3'b101;
        set_src(0, 5'd9, 32'h9999_0009);
        set_src(2, 5'd10, 32'h1010_0010);
        q_addr_a = 5'd9;
        q_addr_b = 5'd10;
        tick();
        flush = 1'b1;
        req_valid = 3'b111;
        set_src(1, 5'd11, 32'h1111_0011);
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_ready: got %b exp 000", req_ready);
        end
        n_checks++;
        if (q_pend_a !== 1'b1 || q_pend_b !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pend_before: got %b%b exp 11",
                     q_pend_a, q_pend_b);
        end
        tick();
        flush = 1'b0;
        req_valid = '0;
        #1;
        n_checks++;
        if (req_ready !== 3'b111 || q_pend_a !== 1'b0 ||
            q_pend_b !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: got rdy=%b pend=%b%b exp 111 00",
                     req_ready, q_pend_a, q_pend_b);
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_write%0d: got %b exp 0", c, wr_en);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 3'b011;
        set_src(0, 5'd6, 32'h6666_0006);
        set_src(1, 5'd7, 32'h7777_0007);
        q_addr_a = 5'd7;
        tick();
        req_valid = '0;
        tick();
        #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd6 || q_pend_a !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_setup: got en=%b a=%0d pend=%b exp 1 6 1",
                     wr_en, wr_addr, q_pend_a);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b exp 0", wr_en);
        end
        n_checks++;
        if (q_pend_a !== 1'b0 || req_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL arst_cleared: got pend=%b rdy=%b exp 0 111",
                     q_pend_a, req_ready);
        end
        #2;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL arst_no_write%0d: got en=%b a=%0d exp 0",
                         c, wr_en, wr_addr);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] na [N];
        logic [DW-1:0] nd [N];
        int g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
            md[i] = '0;
        end
        mptr = 0;
        exp_wen = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_wsrc = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            n_checks++;
            if (wr_en !== exp_wen) begin
                n_fail++;
                $display("FAIL rand_wr_en c%0d: got %b exp %b",
                         cyc, wr_en, exp_wen);
            end else if (exp_wen) begin
                n_checks++;
                if (wr_addr !== exp_waddr || wr_data !== exp_wdata ||
                    wr_src !== 3'(exp_wsrc)) begin
                    n_fail++;
                    $display("FAIL rand_beat c%0d: got a=%0d d=%h s=%0d exp a=%0d d=%h s=%0d",
                             cyc, wr_addr, wr_data, wr_src,
                             exp_waddr, exp_wdata, exp_wsrc);
                end
            end
            flush = ($urandom_range(15) == 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(3) != 0);
                na[i] = AW'($urandom_range(7));
                nd[i] = $urandom;
                set_src(i, na[i], nd[i]);
            end
            q_addr_a = AW'($urandom_range(7));
            q_addr_b = AW'($urandom_range(31));
            #1;
            g = -1;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && mv[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                exp_ready[i] = !flush && (!mv[i] || g == i);
            end
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready c%0d: got %b exp %b",
                         cyc, req_ready, exp_ready);
            end
            n_checks++;
            if (q_pend_a !== model_pend(q_addr_a) ||
                q_pend_b !== model_pend(q_addr_b)) begin
                n_fail++;
                $display("FAIL rand_pend c%0d: got %b%b exp %b%b",
                         cyc, q_pend_a, q_pend_b,
                         model_pend(q_addr_a), model_pend(q_addr_b));
            end
            if (flush) begin
                for (int i = 0; i < N; i++) mv[i] = 1'b0;
                exp_wen = 1'b0;
            end else begin
                exp_wen = (g >= 0);
                if (g >= 0) begin
                    exp_waddr = ma[g];
                    exp_wdata = md[g];
                    exp_wsrc  = g;
                    mptr = (g + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && exp_ready[i]) begin
                        mv[i] = (na[i] != 0);
                        ma[i] = na[i];
                        md[i] = nd[i];
                    end else if (g == i) begin
                        mv[i] = 1'b0;
                    end
                end
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_addr();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
